// File: rtl/regfile_pkg.sv
// Shared widths, constants and FSM state type for the register-file controller.
package regfile_pkg;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    DBG_RD = 2'd2
  } state_e;
endpackage

// File: rtl/regfile_if.sv
// Bundle of pipeline, debug and register-file signals around regfile_ctrl.
//   master : pipeline/debug requester and register file (drives requests, rf_rd*)
//   slave  : regfile_ctrl (drives read data, busy, debug ack, rf_* controls)
interface regfile_if;
  import regfile_pkg::*;

  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [REG_DW-1:0] wb_data;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_DW-1:0] rs_data;
  logic [REG_DW-1:0] rt_data;
  logic              busy;
  logic              dbg_req;
  logic              dbg_wr;
  logic [REG_AW-1:0] dbg_addr;
  logic [REG_DW-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [REG_DW-1:0] dbg_rdata;
  logic [REG_AW-1:0] rf_a1;
  logic [REG_AW-1:0] rf_a2;
  logic [REG_AW-1:0] rf_a3;
  logic [REG_DW-1:0] rf_wd;
  logic              rf_we;
  logic [REG_DW-1:0] rf_rd1;
  logic [REG_DW-1:0] rf_rd2;

  modport master (
    output wb_we, wb_addr, wb_data, rs_addr, rt_addr,
           dbg_req, dbg_wr, dbg_addr, dbg_wdata, rf_rd1, rf_rd2,
    input  rs_data, rt_data, busy, dbg_ack, dbg_rdata,
           rf_a1, rf_a2, rf_a3, rf_wd, rf_we
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, rs_addr, rt_addr,
           dbg_req, dbg_wr, dbg_addr, dbg_wdata, rf_rd1, rf_rd2,
    output rs_data, rt_data, busy, dbg_ack, dbg_rdata,
           rf_a1, rf_a2, rf_a3, rf_wd, rf_we
  );
endinterface

// File: rtl/regfile_bypass.sv
// Write-to-read forwarding for a synchronous-read register file.
// Registers the write committed this cycle and the read addresses issued this
// cycle; next cycle the raw register-file data is replaced by the forwarded
// write on an address match, and address 0 always reads as zero.
//   clk, reset        : clock, async active-high reset
//   i_we/i_wa/i_wd    : write port as presented to the register file
//   i_ra1/i_ra2       : read addresses presented to the register file
//   i_rd1/i_rd2       : register file read data (one cycle later)
//   o_rd1/o_rd2       : corrected read data
//   o_dbg_rd          : corrected data for port 1 (shared with debug reads)
module regfile_bypass
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [REG_DW-1:0] i_wd,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  input  logic [REG_DW-1:0] i_rd1,
  input  logic [REG_DW-1:0] i_rd2,
  output logic [REG_DW-1:0] o_rd1,
  output logic [REG_DW-1:0] o_rd2,
  output logic [REG_DW-1:0] o_dbg_rd
);
  logic              r_wvld;
  logic [REG_AW-1:0] r_wa;
  logic [REG_DW-1:0] r_wd;
  logic [REG_AW-1:0] r_ra1;
  logic [REG_AW-1:0] r_ra2;

  // Capture the write and the read addresses of the current cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wvld <= 1'b0;
      r_wa   <= REG_ZERO;
      r_wd   <= '0;
      r_ra1  <= REG_ZERO;
      r_ra2  <= REG_ZERO;
    end else begin
      r_wvld <= i_we;
      r_wa   <= i_wa;
      r_wd   <= i_wd;
      r_ra1  <= i_ra1;
      r_ra2  <= i_ra2;
    end
  end

  // Address 0 dominates, then forwarding, then the array output.
  always_comb begin
    o_rd1 = i_rd1;
    o_rd2 = i_rd2;
    if (r_ra1 == REG_ZERO)             o_rd1 = '0;
    else if (r_wvld && (r_wa == r_ra1)) o_rd1 = r_wd;
    if (r_ra2 == REG_ZERO)             o_rd2 = '0;
    else if (r_wvld && (r_wa == r_ra2)) o_rd2 = r_wd;
  end

  assign o_dbg_rd = o_rd1;
endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller: clears all registers after reset, arbitrates the
// single write port between pipeline writeback and debug writes, serves debug
// reads by borrowing read port 1 for one stalled cycle, and forwards writes to
// same-cycle reads.
//   clk, reset : clock, async active-high reset
//   bus        : regfile_if.slave (pipeline, debug and register-file signals)
// Build option: define REGFILE_DBG_EN to enable the debug port and DBG_RD state;
// without it debug inputs are ignored and dbg_ack/dbg_rdata stay 0.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave bus
);
  localparam int unsigned CW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              w_rf_we;
  logic [REG_AW-1:0] w_rf_a1;
  logic [REG_AW-1:0] w_rf_a3;
  logic [REG_DW-1:0] w_rf_wd;
  logic              w_busy;
  logic              w_dbg_ack;
  logic [REG_DW-1:0] w_dbg_rdata;
  logic [REG_DW-1:0] w_rs_data;
  logic [REG_DW-1:0] w_rt_data;
  logic [REG_DW-1:0] w_byp_dbg;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= INIT;
    else       r_state <= w_state_nxt;
  end

  // Clear-sweep address counter, only advances in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_cnt <= '0;
    else if (r_state == INIT) r_cnt <= r_cnt + CW'(1);
    else                      r_cnt <= '0;
  end

  // Next state and write-port / read-port-1 steering.
  always_comb begin
    w_state_nxt = r_state;
    w_rf_we     = bus.wb_we && (bus.wb_addr != REG_ZERO);
    w_rf_a1     = bus.rs_addr;
    w_rf_a3     = bus.wb_addr;
    w_rf_wd     = bus.wb_data;
    w_busy      = 1'b0;
    w_dbg_ack   = 1'b0;
    case (r_state)
      INIT: begin
        w_busy  = 1'b1;
        w_rf_we = !reset;
        w_rf_a3 = REG_AW'(r_cnt);
        w_rf_wd = '0;
        if (r_cnt == CW'(NUM_REGS - 1)) w_state_nxt = RUN;
      end
      RUN: begin
`ifdef REGFILE_DBG_EN
        if (bus.dbg_req) begin
          if (bus.dbg_wr) begin
            // Debug write only takes the port when writeback leaves it free.
            if (!bus.wb_we) begin
              w_rf_we   = (bus.dbg_addr != REG_ZERO);
              w_rf_a3   = bus.dbg_addr;
              w_rf_wd   = bus.dbg_wdata;
              w_dbg_ack = 1'b1;
            end
          end else begin
            w_busy      = 1'b1;
            w_rf_a1     = bus.dbg_addr;
            w_state_nxt = DBG_RD;
          end
        end
`endif
      end
      DBG_RD: begin
`ifdef REGFILE_DBG_EN
        w_dbg_ack = 1'b1;
`endif
        w_state_nxt = RUN;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  regfile_bypass u_bypass (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_rf_we),
    .i_wa     (w_rf_a3),
    .i_wd     (w_rf_wd),
    .i_ra1    (w_rf_a1),
    .i_ra2    (bus.rt_addr),
    .i_rd1    (bus.rf_rd1),
    .i_rd2    (bus.rf_rd2),
    .o_rd1    (w_rs_data),
    .o_rd2    (w_rt_data),
    .o_dbg_rd (w_byp_dbg)
  );

`ifdef REGFILE_DBG_EN
  logic [REG_DW-1:0] r_dbg_rdata;

  // Hold the last debug read result after the ack cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_dbg_rdata <= '0;
    else if (r_state == DBG_RD) r_dbg_rdata <= w_byp_dbg;
  end

  assign w_dbg_rdata = (r_state == DBG_RD) ? w_byp_dbg : r_dbg_rdata;
`else
  logic w_dbg_unused;
  assign w_dbg_unused = ^{bus.dbg_req, bus.dbg_wr, bus.dbg_addr, bus.dbg_wdata, w_byp_dbg};
  assign w_dbg_rdata  = '0;
`endif

  assign bus.rf_we     = w_rf_we;
  assign bus.rf_a1     = w_rf_a1;
  assign bus.rf_a2     = bus.rt_addr;
  assign bus.rf_a3     = w_rf_a3;
  assign bus.rf_wd     = w_rf_wd;
  assign bus.busy      = w_busy;
  assign bus.dbg_ack   = w_dbg_ack;
  assign bus.dbg_rdata = w_dbg_rdata;
  assign bus.rs_data   = w_rs_data;
  assign bus.rt_data   = w_rt_data;
endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural synchronous-read register file.
module tb_regfile_ctrl;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_if bus();

  regfile_ctrl #(.NUM_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file model: read-before-write, plus a back door for address 0 tests.
  logic [31:0] mem [32];
  logic        poke;
  logic [4:0]  poke_a;
  logic [31:0] poke_d;
  always @(posedge clk) begin
    if (bus.rf_we) mem[bus.rf_a3] <= bus.rf_wd;
    if (poke)      mem[poke_a]    <= poke_d;
    bus.rf_rd1 <= mem[bus.rf_a1];
    bus.rf_rd2 <= mem[bus.rf_a2];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.rs_addr = '0; bus.rt_addr = '0;
    bus.dbg_req = 1'b0; bus.dbg_wr = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    poke = 1'b0; poke_a = '0; poke_d = '0;
  endtask

  // Checks ncyc INIT cycles; caller has just reached the negedge of the first one.
  task automatic init_seq(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) @(negedge clk);
      bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hFFFF_FFFF;
      bus.dbg_req = 1'b1; bus.dbg_wr = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_wdata = 32'h5555_5555;
      #1;
      chk("init_busy", 32'(bus.busy), 32'd1);
      chk("init_we", 32'(bus.rf_we), 32'd1);
      chk("init_a3", 32'(bus.rf_a3), 32'(i));
      chk("init_wd", bus.rf_wd, 32'd0);
      chk("init_ack", 32'(bus.dbg_ack), 32'd0);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, "_ack"}, 32'(bus.dbg_ack), 32'd0);
    chk({tag, "_rdata"}, bus.dbg_rdata, 32'd0);
  endtask

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        exp_we;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Expected rs/rt in each row answer the addresses of the previous row.
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd0, 1'b1, 32'h0,         32'h0};
    vecs[1] = '{1'b1, 5'd6,  32'h600D_F00D, 5'd6,  5'd5, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd6, 1'b0, 32'h600D_F00D, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0, 1'b0, 32'hDEAD_BEEF, 32'h600D_F00D};
    vecs[4] = '{1'b1, 5'd5,  32'h1234_5678, 5'd5,  5'd5, 1'b1, 32'h0,         32'h0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd6, 1'b0, 32'h1234_5678, 32'h1234_5678};
    vecs[6] = '{1'b1, 5'd31, 32'hCAFE_BABE, 5'd31, 5'd31, 1'b1, 32'h0,        32'h600D_F00D};
    vecs[7] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd1, 1'b0, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[8] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0, 1'b0, 32'hCAFE_BABE, 32'h0};

    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset_checks("rst0");

    // Full clear sweep with writeback and debug requests that must be ignored.
    @(negedge clk);
    reset = 1'b0;
    init_seq(32);
    @(negedge clk);
    idle();
    #1;
    chk("init_done_busy", 32'(bus.busy), 32'd0);

    // Writeback, forwarding and address-0 rows.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.wb_we = vecs[i].wb_we; bus.wb_addr = vecs[i].wb_addr; bus.wb_data = vecs[i].wb_data;
      bus.rs_addr = vecs[i].rs; bus.rt_addr = vecs[i].rt;
      #1;
      chk($sformatf("vec%0d_we", i), 32'(bus.rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_rs", i), bus.rs_data, vecs[i].exp_rs);
      chk($sformatf("vec%0d_rt", i), bus.rt_data, vecs[i].exp_rt);
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
    end

    // Register 0 holding garbage must still read as zero.
    @(negedge clk); idle(); poke = 1'b1; poke_a = 5'd0; poke_d = 32'hFFFF_FFFF;
    @(negedge clk); idle();
    @(negedge clk); idle(); #1;
    chk("r0_rs", bus.rs_data, 32'd0);
    chk("r0_rt", bus.rt_data, 32'd0);

`ifdef REGFILE_DBG_EN
    // Debug write waits for a writeback-free cycle.
    @(negedge clk); idle();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
    bus.dbg_req = 1'b1; bus.dbg_wr = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_wdata = 32'h1234;
    #1;
    chk("dw_wb_a3", 32'(bus.rf_a3), 32'd3);
    chk("dw_wb_wd", bus.rf_wd, 32'h33);
    chk("dw_wb_ack", 32'(bus.dbg_ack), 32'd0);
    @(negedge clk); bus.wb_we = 1'b0; #1;
    chk("dw_we", 32'(bus.rf_we), 32'd1);
    chk("dw_a3", 32'(bus.rf_a3), 32'd7);
    chk("dw_wd", bus.rf_wd, 32'h1234);
    chk("dw_ack", 32'(bus.dbg_ack), 32'd1);
    @(negedge clk); idle(); bus.rs_addr = 5'd7; bus.rt_addr = 5'd3; #1;
    chk("dw_ack_drop", 32'(bus.dbg_ack), 32'd0);
    @(negedge clk); idle(); #1;
    chk("dw_r7", bus.rs_data, 32'h1234);
    chk("dw_r3", bus.rt_data, 32'h33);

    // Debug write to r0 is acked but not committed.
    @(negedge clk); idle();
    bus.dbg_req = 1'b1; bus.dbg_wr = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_wdata = 32'hFFFF;
    #1;
    chk("dw0_we", 32'(bus.rf_we), 32'd0);
    chk("dw0_ack", 32'(bus.dbg_ack), 32'd1);

    // Debug read of r9.
    @(negedge clk); idle(); bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hA5A5_A5A5;
    @(negedge clk); idle(); bus.rs_addr = 5'd2;
    bus.dbg_req = 1'b1; bus.dbg_wr = 1'b0; bus.dbg_addr = 5'd9;
    #1;
    chk("dr_issue_busy", 32'(bus.busy), 32'd1);
    chk("dr_issue_a1", 32'(bus.rf_a1), 32'd9);
    chk("dr_issue_ack", 32'(bus.dbg_ack), 32'd0);
    @(negedge clk); #1;
    chk("dr_busy", 32'(bus.busy), 32'd0);
    chk("dr_ack", 32'(bus.dbg_ack), 32'd1);
    chk("dr_rdata", bus.dbg_rdata, 32'hA5A5_A5A5);
    chk("dr_a1", 32'(bus.rf_a1), 32'd2);
    @(negedge clk); idle(); #1;
    chk("dr_ack_drop", 32'(bus.dbg_ack), 32'd0);
    chk("dr_hold", bus.dbg_rdata, 32'hA5A5_A5A5);

    // Debug read forwarded from a writeback in the issue cycle.
    @(negedge clk); idle();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'h1010_1010;
    bus.dbg_req = 1'b1; bus.dbg_wr = 1'b0; bus.dbg_addr = 5'd10;
    #1;
    chk("drb_busy", 32'(bus.busy), 32'd1);
    chk("drb_we", 32'(bus.rf_we), 32'd1);
    @(negedge clk); bus.wb_we = 1'b0; #1;
    chk("drb_ack", 32'(bus.dbg_ack), 32'd1);
    chk("drb_rdata", bus.dbg_rdata, 32'h1010_1010);
    @(negedge clk); idle();
`else
    // Debug port absent: requests have no effect.
    @(negedge clk); idle();
    bus.dbg_req = 1'b1; bus.dbg_wr = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_wdata = 32'h1234;
    #1;
    chk("nd_w_we", 32'(bus.rf_we), 32'd0);
    chk("nd_w_ack", 32'(bus.dbg_ack), 32'd0);
    @(negedge clk); bus.dbg_wr = 1'b0; bus.dbg_addr = 5'd9; bus.rs_addr = 5'd4; #1;
    chk("nd_r_busy", 32'(bus.busy), 32'd0);
    chk("nd_r_ack", 32'(bus.dbg_ack), 32'd0);
    chk("nd_r_a1", 32'(bus.rf_a1), 32'd4);
    @(negedge clk); idle(); bus.rs_addr = 5'd7; #1;
    chk("nd_rdata", bus.dbg_rdata, 32'd0);
    chk("nd_busy2", 32'(bus.busy), 32'd0);
    @(negedge clk); idle(); #1;
    chk("nd_r7", bus.rs_data, 32'd0);
`endif

    // Reset from RUN, then a reset in the middle of the clear sweep.
    @(negedge clk); idle(); reset = 1'b1; #1;
    reset_checks("rst1");
    @(negedge clk); reset = 1'b0;
    init_seq(18);
    reset = 1'b1; #1;
    reset_checks("rst2");
    @(negedge clk); reset = 1'b0;
    init_seq(32);
    @(negedge clk); idle(); bus.rs_addr = 5'd5; bus.rt_addr = 5'd31; #1;
    chk("reinit_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); idle(); #1;
    chk("reinit_r5", bus.rs_data, 32'd0);
    chk("reinit_r31", bus.rt_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
